// File: rtl/axi4_rab_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_rab_pkg
//  Description : Shared types and constants for the AR round-robin arbiter.
//                Holds the attribute-bundle layout and the arbiter states.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi4_rab_pkg;

    // Packed read-address attribute bundle, MSB first:
    // {arlen[7:0], arsize[2:0], arburst[1:0], arlock, arprot[2:0], arcache[3:0]}
    localparam int ARATTR_W  = 21;
    localparam int LEN_OFS   = 13;
    localparam int SIZE_OFS  = 10;
    localparam int BURST_OFS = 8;
    localparam int LOCK_OFS  = 7;
    localparam int PROT_OFS  = 4;
    localparam int CACHE_OFS = 0;

    // IDLE selects a winner; LOCKED presents it downstream until accepted
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_core.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_core
//  Description : Stateless round-robin priority rotate. Returns the first
//                eligible requester found scanning upward from
//                last_grant+1, wrapping modulo NUM_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_core #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_elig,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any_req
);

    logic [IDX_W:0]         w_start;
    logic [2*NUM_REQ-1:0]   w_dbl;
    logic [2*NUM_REQ-1:0]   w_rot;

    // Doubling the request vector turns the wrap-around into a plain shift:
    // bit p of w_rot is requester (last_grant+1+p) mod NUM_REQ.
    assign w_start = {1'b0, i_last_grant} + 1'b1;
    assign w_dbl   = {i_elig, i_elig};
    assign w_rot   = w_dbl >> w_start;

    // Lowest set bit of the rotated vector wins; map it back to an index
    always_comb begin
        int w_sum;
        w_sum     = 0;
        o_winner  = '0;
        o_any_req = 1'b0;
        for (int p = 0; p < NUM_REQ; p++) begin
            if (!o_any_req && w_rot[p]) begin
                o_any_req = 1'b1;
                w_sum     = int'(w_start) + p;
                if (w_sum >= NUM_REQ) begin
                    w_sum = w_sum - NUM_REQ;
                end
                o_winner  = IDX_W'(w_sum);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4_ar_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_ar_rr_arbiter
//  Description : Round-robin sharing of one AXI4 read-address channel among
//                NUM_REQ masters. Grant is held until the AR handshake,
//                the requester index is prepended to ARID, the R channel is
//                routed back by the RID MSBs, and each requester is limited
//                to MAX_OUT open bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_ar_rr_arbiter
    import axi4_rab_pkg::*;
#(
    parameter  int NUM_REQ        = 2,
    parameter  int AXI_ID_WIDTH   = 4,
    parameter  int AXI_USER_WIDTH = 4,
    parameter  int AXI_DATA_WIDTH = 64,
    parameter  int MAX_OUT        = 4,
    localparam int IDX_W          = $clog2(NUM_REQ),
    localparam int MID_W          = AXI_ID_WIDTH + IDX_W
) (
    input  logic                              axi4_aclk,
    input  logic                              axi4_arst,
    // upstream AR
    input  logic [NUM_REQ*AXI_ID_WIDTH-1:0]   s_axi4_arid,
    input  logic [NUM_REQ*32-1:0]             s_axi4_araddr,
    input  logic [NUM_REQ*21-1:0]             s_axi4_arattr,
    input  logic [NUM_REQ*AXI_USER_WIDTH-1:0] s_axi4_aruser,
    input  logic [NUM_REQ-1:0]                s_axi4_arvalid,
    output logic [NUM_REQ-1:0]                s_axi4_arready,
    // downstream AR
    output logic [MID_W-1:0]                  m_axi4_arid,
    output logic [31:0]                       m_axi4_araddr,
    output logic [20:0]                       m_axi4_arattr,
    output logic [AXI_USER_WIDTH-1:0]         m_axi4_aruser,
    output logic                              m_axi4_arvalid,
    input  logic                              m_axi4_arready,
    // downstream R
    input  logic [MID_W-1:0]                  m_axi4_rid,
    input  logic [AXI_DATA_WIDTH-1:0]         m_axi4_rdata,
    input  logic [1:0]                        m_axi4_rresp,
    input  logic                              m_axi4_rlast,
    input  logic                              m_axi4_rvalid,
    output logic                              m_axi4_rready,
    // upstream R
    output logic [AXI_ID_WIDTH-1:0]           s_axi4_rid,
    output logic [AXI_DATA_WIDTH-1:0]         s_axi4_rdata,
    output logic [1:0]                        s_axi4_rresp,
    output logic                              s_axi4_rlast,
    output logic [NUM_REQ-1:0]                s_axi4_rvalid,
    input  logic [NUM_REQ-1:0]                s_axi4_rready,
    output logic                              rid_err
);

    localparam int CNT_W    = $clog2(MAX_OUT + 1);
    localparam int IDX_SPAN = 1 << IDX_W;

    arb_state_t                 r_state;
    logic [IDX_W-1:0]           r_grant;
    logic [IDX_W-1:0]           r_last_grant;
    logic [CNT_W-1:0]           r_cnt [NUM_REQ];
    logic                       r_rid_err;

    logic [AXI_ID_WIDTH-1:0]    w_arid   [NUM_REQ];
    logic [31:0]                w_araddr [NUM_REQ];
    logic [ARATTR_W-1:0]        w_arattr [NUM_REQ];
    logic [AXI_USER_WIDTH-1:0]  w_aruser [NUM_REQ];

    logic [NUM_REQ-1:0]         w_elig;
    logic [NUM_REQ-1:0]         w_inc;
    logic [NUM_REQ-1:0]         w_dec;
    logic [NUM_REQ-1:0]         w_cnt_zero;
    logic [IDX_W-1:0]           w_winner;
    logic                       w_any_req;
    logic                       w_locked;
    logic                       w_ar_hs;
    logic                       w_r_hs;
    logic [IDX_W-1:0]           w_ridx;
    logic                       w_ridx_ok;
    logic [IDX_SPAN-1:0]        w_rready_map;

    assign w_locked = (r_state == LOCKED);
    assign w_ar_hs  = w_locked & m_axi4_arready;
    assign w_ridx   = m_axi4_rid[MID_W-1 -: IDX_W];
    assign w_r_hs   = m_axi4_rvalid & m_axi4_rready;

    // Per-requester slicing, eligibility, ARREADY steering and R routing
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign w_arid[gi]         = s_axi4_arid[gi*AXI_ID_WIDTH +: AXI_ID_WIDTH];
        assign w_araddr[gi]       = s_axi4_araddr[gi*32 +: 32];
        assign w_arattr[gi]       = s_axi4_arattr[gi*ARATTR_W +: ARATTR_W];
        assign w_aruser[gi]       = s_axi4_aruser[gi*AXI_USER_WIDTH +: AXI_USER_WIDTH];
        assign w_elig[gi]         = s_axi4_arvalid[gi] & (r_cnt[gi] < CNT_W'(MAX_OUT));
        assign s_axi4_arready[gi] = w_locked & (r_grant == IDX_W'(gi)) & m_axi4_arready;
        assign s_axi4_rvalid[gi]  = m_axi4_rvalid & w_ridx_ok & (w_ridx == IDX_W'(gi));
        assign w_inc[gi]          = w_ar_hs & (r_grant == IDX_W'(gi));
        assign w_dec[gi]          = w_r_hs & m_axi4_rlast & w_ridx_ok & (w_ridx == IDX_W'(gi));
        assign w_cnt_zero[gi]     = (r_cnt[gi] == '0);
    end

    // Unused index codes (non power-of-two NUM_REQ) always accept and drop
    if (IDX_SPAN > NUM_REQ) begin : g_pad
        assign w_rready_map = {{(IDX_SPAN-NUM_REQ){1'b1}}, s_axi4_rready};
        assign w_ridx_ok    = ({1'b0, w_ridx} < (IDX_W+1)'(NUM_REQ));
    end else begin : g_nopad
        assign w_rready_map = s_axi4_rready;
        assign w_ridx_ok    = 1'b1;
    end

    rr_arbiter_core #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_core (
        .i_elig       (w_elig),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any_req    (w_any_req)
    );

    // Grant FSM: pick a winner in IDLE, hold it in LOCKED until accepted
    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_winner;
                        r_state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (m_axi4_arready) begin
                        r_last_grant <= r_grant;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outstanding-burst counters; a coincident issue and retire cancel out
    always_ff @(posedge axi4_aclk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (axi4_arst) begin
                r_cnt[i] <= '0;
            end else if (w_inc[i] && !w_dec[i]) begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
            end else if (w_dec[i] && !w_inc[i] && !w_cnt_zero[i]) begin
                r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    // Sticky flag for beats to a nonexistent requester or a retire underflow
    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst) begin
            r_rid_err <= 1'b0;
        end else if ((w_r_hs && !w_ridx_ok) || (|(w_dec & w_cnt_zero))) begin
            r_rid_err <= 1'b1;
        end
    end

    assign m_axi4_arvalid = w_locked;
    assign m_axi4_arid    = {r_grant, w_arid[r_grant]};
    assign m_axi4_araddr  = w_araddr[r_grant];
    assign m_axi4_arattr  = w_arattr[r_grant];
    assign m_axi4_aruser  = w_aruser[r_grant];

    assign m_axi4_rready  = w_rready_map[w_ridx];
    assign s_axi4_rid     = m_axi4_rid[AXI_ID_WIDTH-1:0];
    assign s_axi4_rdata   = m_axi4_rdata;
    assign s_axi4_rresp   = m_axi4_rresp;
    assign s_axi4_rlast   = m_axi4_rlast;
    assign rid_err        = r_rid_err;

endmodule
`default_nettype wire

// File: tb/tb_axi4_ar_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_ar_rr_arbiter
//  Description : Directed self-checking bench for axi4_ar_rr_arbiter with a
//                two-requester instance and a three-requester instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_ar_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // two-requester instance
    logic [7:0]  s_arid;
    logic [63:0] s_araddr;
    logic [41:0] s_arattr;
    logic [7:0]  s_aruser;
    logic [1:0]  s_arvalid, s_arready;
    logic [4:0]  m_arid;
    logic [31:0] m_araddr;
    logic [20:0] m_arattr;
    logic [3:0]  m_aruser;
    logic        m_arvalid, m_arready;
    logic [4:0]  m_rid;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast, m_rvalid, m_rready;
    logic [3:0]  s_rid;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [1:0]  s_rvalid, s_rready;
    logic        rid_err;

    // three-requester instance
    logic [2:0]  s3_arready, s3_rvalid;
    logic [2:0]  s3_rready;
    logic [5:0]  m3_arid, m3_rid;
    logic [31:0] m3_araddr;
    logic [20:0] m3_arattr;
    logic [3:0]  m3_aruser, s3_rid;
    logic        m3_arvalid, m3_rlast, m3_rvalid, m3_rready, s3_rlast, rid_err3;
    logic [63:0] s3_rdata;
    logic [1:0]  s3_rresp;

    axi4_ar_rr_arbiter dut (
        .axi4_aclk(clk), .axi4_arst(rst),
        .s_axi4_arid(s_arid), .s_axi4_araddr(s_araddr), .s_axi4_arattr(s_arattr),
        .s_axi4_aruser(s_aruser), .s_axi4_arvalid(s_arvalid), .s_axi4_arready(s_arready),
        .m_axi4_arid(m_arid), .m_axi4_araddr(m_araddr), .m_axi4_arattr(m_arattr),
        .m_axi4_aruser(m_aruser), .m_axi4_arvalid(m_arvalid), .m_axi4_arready(m_arready),
        .m_axi4_rid(m_rid), .m_axi4_rdata(m_rdata), .m_axi4_rresp(m_rresp),
        .m_axi4_rlast(m_rlast), .m_axi4_rvalid(m_rvalid), .m_axi4_rready(m_rready),
        .s_axi4_rid(s_rid), .s_axi4_rdata(s_rdata), .s_axi4_rresp(s_rresp),
        .s_axi4_rlast(s_rlast), .s_axi4_rvalid(s_rvalid), .s_axi4_rready(s_rready),
        .rid_err(rid_err)
    );

    axi4_ar_rr_arbiter #(.NUM_REQ(3)) dut3 (
        .axi4_aclk(clk), .axi4_arst(rst),
        .s_axi4_arid(12'h0), .s_axi4_araddr(96'h0), .s_axi4_arattr(63'h0),
        .s_axi4_aruser(12'h0), .s_axi4_arvalid(3'b000), .s_axi4_arready(s3_arready),
        .m_axi4_arid(m3_arid), .m_axi4_araddr(m3_araddr), .m_axi4_arattr(m3_arattr),
        .m_axi4_aruser(m3_aruser), .m_axi4_arvalid(m3_arvalid), .m_axi4_arready(1'b0),
        .m_axi4_rid(m3_rid), .m_axi4_rdata(64'h0), .m_axi4_rresp(2'b00),
        .m_axi4_rlast(m3_rlast), .m_axi4_rvalid(m3_rvalid), .m_axi4_rready(m3_rready),
        .s_axi4_rid(s3_rid), .s_axi4_rdata(s3_rdata), .s_axi4_rresp(s3_rresp),
        .s_axi4_rlast(s3_rlast), .s_axi4_rvalid(s3_rvalid), .s_axi4_rready(s3_rready),
        .rid_err(rid_err3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        s_arid    = {4'h9, 4'h3};
        s_araddr  = {32'h2000_0040, 32'h0000_1000};
        s_arattr  = {21'h0F00C3, 21'h0A5A5A};
        s_aruser  = {4'hB, 4'h6};
        s_arvalid = 2'b00;
        m_arready = 1'b0;
        m_rid     = '0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;
        m_rvalid  = 1'b0;
        s_rready  = 2'b00;
        m3_rid    = '0;
        m3_rlast  = 1'b0;
        m3_rvalid = 1'b0;
        s3_rready = 3'b000;

        // ---- reset state ----
        do_reset();
        chk("rst_arvalid", 64'(m_arvalid), 64'h0);
        chk("rst_arready", 64'(s_arready), 64'h0);
        chk("rst_rid_err", 64'(rid_err), 64'h0);
        chk("rst_cnt0", 64'(dut.r_cnt[0]), 64'h0);

        // ---- single request from req0 ----
        s_arvalid = 2'b01;
        m_arready = 1'b1;
        #1;
        chk("t1_no_comb_path", 64'(m_arvalid), 64'h0);
        cyc();
        chk("t1_arvalid", 64'(m_arvalid), 64'h1);
        chk("t1_arid", 64'(m_arid), 64'h03);
        chk("t1_araddr", 64'(m_araddr), 64'h1000);
        chk("t1_arattr", 64'(m_arattr), 64'h0A5A5A);
        chk("t1_aruser", 64'(m_aruser), 64'h6);
        chk("t1_arready", 64'(s_arready), 64'h1);
        cyc();
        s_arvalid = 2'b00;
        chk("t1_arready_drop", 64'(s_arready), 64'h0);
        chk("t1_arvalid_drop", 64'(m_arvalid), 64'h0);
        chk("t1_cnt0", 64'(dut.r_cnt[0]), 64'h1);
        cyc();
        chk("t1_no_regrant", 64'(s_arready), 64'h0);

        // ---- alternating grants, one AR every 2 cycles ----
        do_reset();
        s_arvalid = 2'b11;
        m_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t2_grant_idx", 64'(m_arid[4]), 64'(k % 2));
            chk("t2_arready", 64'(s_arready), 64'(1 << (k % 2)));
            cyc();
            chk("t2_gap", 64'(m_arvalid), 64'h0);
        end
        s_arvalid = 2'b00;

        // ---- throttle req1 at MAX_OUT ----
        do_reset();
        s_arvalid = 2'b10;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t3_req1_arid", 64'(m_arid), 64'h19);
            cyc();
        end
        chk("t3_cnt1_full", 64'(dut.r_cnt[1]), 64'h4);
        s_arvalid = 2'b11;
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("t3_req0_served", 64'(m_arid), 64'h03);
            chk("t3_req1_held", 64'(s_arready), 64'h1);
            cyc();
        end
        s_arvalid = 2'b10;
        cyc();
        chk("t3_throttled_idle", 64'(m_arvalid), 64'h0);
        m_rid    = 5'h15;
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        s_rready = 2'b10;
        #1;
        chk("t3_r_rvalid", 64'(s_rvalid), 64'h2);
        chk("t3_r_rready", 64'(m_rready), 64'h1);
        chk("t3_r_rid", 64'(s_rid), 64'h5);
        cyc();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = 2'b00;
        chk("t3_cnt1_dec", 64'(dut.r_cnt[1]), 64'h3);
        cyc();
        chk("t3_regrant_valid", 64'(m_arvalid), 64'h1);
        chk("t3_regrant_arid", 64'(m_arid), 64'h19);
        cyc();
        s_arvalid = 2'b00;

        // ---- R beats to req1: rlast=0 then rlast=1 ----
        m_rid    = 5'h17;
        m_rdata  = 64'hDEAD_BEEF_0123_4567;
        m_rresp  = 2'b01;
        m_rvalid = 1'b1;
        m_rlast  = 1'b0;
        s_rready = 2'b00;
        #1;
        chk("t4_b0_rvalid", 64'(s_rvalid), 64'h2);
        chk("t4_b0_rid", 64'(s_rid), 64'h7);
        chk("t4_b0_rready_lo", 64'(m_rready), 64'h0);
        s_rready = 2'b10;
        #1;
        chk("t4_b0_rready_hi", 64'(m_rready), 64'h1);
        cyc();
        chk("t4_cnt_nonlast", 64'(dut.r_cnt[1]), 64'h4);
        m_rlast = 1'b1;
        m_rdata = 64'h0F0F_1234_5678_9ABC;
        #1;
        chk("t4_b1_rvalid", 64'(s_rvalid), 64'h2);
        chk("t4_b1_rid", 64'(s_rid), 64'h7);
        chk("t4_b1_rdata", s_rdata, 64'h0F0F_1234_5678_9ABC);
        chk("t4_b1_rresp", 64'(s_rresp), 64'h1);
        chk("t4_b1_rlast", 64'(s_rlast), 64'h1);
        cyc();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = 2'b00;
        chk("t4_cnt_last", 64'(dut.r_cnt[1]), 64'h3);
        chk("t4_no_err", 64'(rid_err), 64'h0);

        // ---- downstream stall: grant and fields stay put ----
        m_arready = 1'b0;
        s_arvalid = 2'b10;
        cyc();
        s_arvalid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            chk("t5_arvalid", 64'(m_arvalid), 64'h1);
            chk("t5_arid", 64'(m_arid), 64'h19);
            chk("t5_araddr", 64'(m_araddr), 64'h2000_0040);
            chk("t5_arattr", 64'(m_arattr), 64'h0F00C3);
            chk("t5_arready", 64'(s_arready), 64'h0);
            cyc();
        end
        m_arready = 1'b1;
        #1;
        chk("t5_release", 64'(s_arready), 64'h2);
        cyc();
        cyc();
        chk("t5_next_req0", 64'(m_arid), 64'h03);
        s_arvalid = 2'b00;
        m_arready = 1'b0;

        // ---- three requesters: legal route then illegal index ----
        m3_rid    = 6'h29;
        m3_rvalid = 1'b1;
        s3_rready = 3'b100;
        #1;
        chk("t6_legal_rvalid", 64'(s3_rvalid), 64'h4);
        chk("t6_legal_rready", 64'(m3_rready), 64'h1);
        chk("t6_legal_rid", 64'(s3_rid), 64'h9);
        m3_rid    = 6'h32;
        s3_rready = 3'b000;
        #1;
        chk("t6_bad_rready", 64'(m3_rready), 64'h1);
        chk("t6_bad_rvalid", 64'(s3_rvalid), 64'h0);
        chk("t6_err_before", 64'(rid_err3), 64'h0);
        cyc();
        m3_rvalid = 1'b0;
        chk("t6_err_set", 64'(rid_err3), 64'h1);
        cyc();
        chk("t6_err_sticky", 64'(rid_err3), 64'h1);
        do_reset();
        chk("t6_err_cleared", 64'(rid_err3), 64'h0);

        // ---- retire with no open burst: underflow ----
        m3_rid    = 6'h05;
        m3_rvalid = 1'b1;
        m3_rlast  = 1'b1;
        s3_rready = 3'b001;
        cyc();
        m3_rvalid = 1'b0;
        m3_rlast  = 1'b0;
        s3_rready = 3'b000;
        chk("t7_underflow_err", 64'(rid_err3), 64'h1);
        chk("t7_cnt_stays0", 64'(dut3.r_cnt[0]), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_ar_rr_arbiter.md
Name: axi4_ar_rr_arbiter

Overview:
- Shares one downstream AXI4 read-address channel (the AR buffer / VA-to-PA path) between NUM_REQ upstream read masters.
- Round-robin arbitration; each grant is held until the AR handshake completes.
- Prepends the requester index to ARID and demultiplexes the R channel back to the owning requester using the RID MSBs.
- A per-requester outstanding-burst counter throttles any requester that reaches MAX_OUT open bursts.

Parameters:
- NUM_REQ, 2, number of upstream requesters (>=2); IDX_W = $clog2(NUM_REQ).
- AXI_ID_WIDTH, 4, upstream ID width; downstream ID width is AXI_ID_WIDTH+IDX_W.
- AXI_USER_WIDTH, 4, ARUSER width.
- AXI_DATA_WIDTH, 64, RDATA width.
- MAX_OUT, 4, maximum outstanding bursts per requester (>=1); counter width CNT_W = $clog2(MAX_OUT+1).

Ports:
- axi4_aclk  in  1  clock; all logic is on the rising edge.
- axi4_arst  in  1  synchronous, active-high reset.
- s_axi4_arid  in  NUM_REQ*AXI_ID_WIDTH  per-requester ARID, packed; requester i occupies slice i.
- s_axi4_araddr  in  NUM_REQ*32  per-requester ARADDR.
- s_axi4_arattr  in  NUM_REQ*21  per-requester {arlen[7:0], arsize[2:0], arburst[1:0], arlock, arprot[2:0], arcache[3:0]}, MSB first.
- s_axi4_aruser  in  NUM_REQ*AXI_USER_WIDTH  per-requester ARUSER.
- s_axi4_arvalid  in  NUM_REQ  per-requester ARVALID.
- s_axi4_arready  out  NUM_REQ  per-requester ARREADY.
- m_axi4_arid  out  AXI_ID_WIDTH+IDX_W  {grant index, granted ARID}.
- m_axi4_araddr  out  32  granted ARADDR.
- m_axi4_arattr  out  21  granted attribute bundle, same packing as s_axi4_arattr.
- m_axi4_aruser  out  AXI_USER_WIDTH  granted ARUSER.
- m_axi4_arvalid  out  1  downstream ARVALID.
- m_axi4_arready  in  1  downstream ARREADY.
- m_axi4_rid  in  AXI_ID_WIDTH+IDX_W  downstream RID.
- m_axi4_rdata  in  AXI_DATA_WIDTH  downstream RDATA.
- m_axi4_rresp  in  2  downstream RRESP.
- m_axi4_rlast  in  1  downstream RLAST.
- m_axi4_rvalid  in  1  downstream RVALID.
- m_axi4_rready  out  1  downstream RREADY.
- s_axi4_rid  out  AXI_ID_WIDTH  RID with the index MSBs stripped; broadcast to all requesters.
- s_axi4_rdata  out  AXI_DATA_WIDTH  RDATA, broadcast to all requesters.
- s_axi4_rresp  out  2  RRESP, broadcast to all requesters.
- s_axi4_rlast  out  1  RLAST, broadcast to all requesters.
- s_axi4_rvalid  out  NUM_REQ  per-requester RVALID.
- s_axi4_rready  in  NUM_REQ  per-requester RREADY.
- rid_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (axi4_arst=1 at a clock edge):
  - state=IDLE; grant=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
  - All outstanding counters cnt[i]=0; rid_err=0.
  - Outputs: m_axi4_arvalid=0 and s_axi4_arready=0 while in IDLE.
  - Reset asserted in LOCKED aborts the pending AR: m_axi4_arvalid drops on the next cycle. This is legal only under reset.
- Eligibility: elig[i] = s_axi4_arvalid[i] & (cnt[i] < MAX_OUT).
- IDLE state:
  - If any elig bit is set, the winner is the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Next cycle: grant=winner, state=LOCKED.
  - If no elig bit is set, stay in IDLE.
- LOCKED state:
  - m_axi4_arvalid=1.
  - m_axi4_ar* fields are combinationally muxed from requester grant; m_axi4_arid = {grant, s_axi4_arid[grant]}.
  - s_axi4_arready[grant] = m_axi4_arready; all other ARREADY bits are 0.
  - On m_axi4_arvalid & m_axi4_arready: last_grant=grant, cnt[grant]+=1, state=IDLE.
- Throughput and latency:
  - Maximum rate is one AR every 2 cycles.
  - Latency from s_axi4_arvalid to m_axi4_arvalid is 1 cycle when the requester wins.
  - No combinational path from s_axi4_arvalid to m_axi4_arvalid.
- R demux (combinational):
  - idx = m_axi4_rid[MSB -: IDX_W].
  - s_axi4_rvalid[i] = m_axi4_rvalid & (idx==i).
  - m_axi4_rready = s_axi4_rready[idx].
  - rdata, rresp, rlast and rid (low AXI_ID_WIDTH bits of m_axi4_rid) are broadcast to all requesters.
- Illegal index: if idx >= NUM_REQ, m_axi4_rready=1 (beat dropped), no s_axi4_rvalid is asserted, and rid_err is set on the handshake.
- Counter decrement: on an R handshake with rlast=1, cnt[idx]-=1.
- Simultaneous increment and decrement on the same counter in one cycle: the value is unchanged.
- Counter underflow: an rlast for a requester with cnt=0 leaves cnt at 0 and sets rid_err.
- Throttled requester: a requester with cnt=MAX_OUT is skipped by the arbiter. Its pending ARVALID is held with no ARREADY until a decrement makes it eligible again.
- A requester cannot be skipped while it holds the grant (grant lock): an ARVALID that is already granted is never withdrawn by the arbiter.

Decomposition:
- Package axi4_rab_pkg:
  - ARATTR_W=21 and the field offsets LEN_OFS=13, SIZE_OFS=10, BURST_OFS=8, LOCK_OFS=7, PROT_OFS=4, CACHE_OFS=0.
  - arb_state_t enum {IDLE, LOCKED}.
- One sub-module: rr_arbiter_core.
  - Inputs: elig vector, last_grant.
  - Outputs: winner index and any_req.
  - Purely combinational priority rotate; the core owns no state.

Test Plan:
- Reset release, then only req0 asserts ARVALID with arid=3, araddr=0x1000 -> m_axi4_arvalid rises 1 cycle later with m_axi4_arid=0x03, araddr=0x1000; with m_arready=1, s_arready[0] pulses once and cnt[0]=1.
- req0 and req1 both valid continuously, m_arready=1 -> grants alternate 0,1,0,1, with one AR handshake every 2 cycles.
- MAX_OUT=4: req1 issues 4 ARs with no R returning -> the 5th is held (s_arready[1]=0) while req0 keeps being served; one R beat with rid=0x1_5 and rlast=1 -> req1 is granted within 2 cycles.
- R beat with rid={1,4'h7}, rlast=0, then rlast=1 -> s_rvalid=2'b10 and s_rid=7 on both beats; m_rready follows s_rready[1]; cnt[1] decrements only on the rlast beat.
- m_arready held 0 for 5 cycles during LOCKED -> m_arvalid and all fields stay stable, and the grant does not move even though req0 is also valid.
- NUM_REQ=3 with rid index 3 -> m_rready=1, no s_rvalid asserted, rid_err=1 and stays 1 until reset.
